// File: rtl/hdlc_rxbuf_ctrl.sv
// HDLC receive-buffer readout controller.
// On a receiver end-of-frame interrupt, reads the frame length slot, then the
// frame bytes from address 0, runs CRC-16/X.25 over every byte and streams the
// payload on a valid/ready port. One interrupt can be queued while busy; any
// further ones are counted as dropped.
// Optional build macro: HDLC_RXBUF_FCS_PASS_EN streams the two FCS bytes as well.
//
// state    | meaning
// IDLE     | waiting for an interrupt event or a pending interrupt
// RD_LEN   | read strobe on the length slot
// WAIT_LEN | latch length, seed CRC, reject short frames
// ISSUE    | read strobe on frame byte idx
// CAPT     | fold byte into CRC, load output byte if it is to be streamed
// STREAM   | hold output byte until the sink accepts it
// NEXT     | advance idx, loop or finish
// CHECK    | compare CRC against the good-frame residual
// DONE     | one-cycle completion pulse, status updated
module hdlc_rxbuf_ctrl #(
    parameter logic [8:0]  LEN_ADDR = 9'd511,
    parameter logic [7:0]  MIN_LEN  = 8'd3,
    parameter logic [15:0] CRC_RES  = 16'hF0B8
) (
    input  logic       clkr,
    input  logic       rst,
    input  logic       rx_int,
    output logic       ram_rd_en,
    output logic [8:0] ram_rd_addr,
    input  logic [7:0] ram_rd_data,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    typedef enum logic [3:0] {
        IDLE, RD_LEN, WAIT_LEN, ISSUE, CAPT, STREAM, NEXT, CHECK, DONE
    } state_t;

    state_t      state_q, state_d;
    logic        rx_q;
    logic        pend_q, pend_d;
    logic [7:0]  drop_q, drop_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  mdata_q, mdata_d;
    logic        mlast_q, mlast_d;
    logic        ok_q, ok_d;
    logic        ferr_q, ferr_d;
    logic        event_w;

    // Reflected CRC-16 (poly 0x8408), one byte LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    assign event_w = rx_int & ~rx_q;

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clkr or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rx_q    <= 1'b0;
            pend_q  <= 1'b0;
            drop_q  <= 8'h00;
            len_q   <= 8'h00;
            idx_q   <= 8'h00;
            crc_q   <= 16'hFFFF;
            mdata_q <= 8'h00;
            mlast_q <= 1'b0;
            ok_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_int;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            crc_q   <= crc_d;
            mdata_q <= mdata_d;
            mlast_q <= mlast_d;
            ok_q    <= ok_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state, interrupt queueing and RAM read strobes.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        drop_d      = drop_q;
        len_d       = len_q;
        idx_d       = idx_q;
        crc_d       = crc_q;
        mdata_d     = mdata_q;
        mlast_d     = mlast_q;
        ok_d        = ok_q;
        ferr_d      = ferr_q;
        ram_rd_en   = 1'b0;
        ram_rd_addr = 9'h000;

        // DONE still counts as busy, so an event there lands in pending.
        if (event_w && state_q != IDLE) begin
            if (!pend_q)
                pend_d = 1'b1;
            else if (drop_q != 8'hFF)
                drop_d = drop_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (event_w || pend_q) begin
                    state_d = RD_LEN;
                    // Serve pending first; a simultaneous new event re-queues.
                    if (pend_q)
                        pend_d = event_w;
                end
            end
            RD_LEN: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = LEN_ADDR;
                state_d     = WAIT_LEN;
            end
            WAIT_LEN: begin
                len_d = ram_rd_data;
                idx_d = 8'h00;
                crc_d = 16'hFFFF;
                if (ram_rd_data < MIN_LEN) begin
                    ok_d    = 1'b0;
                    ferr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = {1'b0, idx_q};
                state_d     = CAPT;
            end
            CAPT: begin
                crc_d = crc_byte(crc_q, ram_rd_data);
`ifdef HDLC_RXBUF_FCS_PASS_EN
                mdata_d = ram_rd_data;
                mlast_d = (idx_q == len_q - 8'd1);
                state_d = STREAM;
`else
                if (idx_q < len_q - 8'd2) begin
                    mdata_d = ram_rd_data;
                    mlast_d = (idx_q == len_q - 8'd3);
                    state_d = STREAM;
                end else begin
                    state_d = NEXT;
                end
`endif
            end
            STREAM: begin
                if (m_ready)
                    state_d = NEXT;
            end
            NEXT: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == len_q - 8'd1) ? CHECK : ISSUE;
            end
            CHECK: begin
                ok_d    = (crc_q == CRC_RES);
                ferr_d  = (crc_q != CRC_RES);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_valid    = (state_q == STREAM);
    assign m_last     = (state_q == STREAM) & mlast_q;
    assign m_data     = mdata_q;
    assign frame_done = (state_q == DONE);
    assign frame_ok   = ok_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);
    assign drop_cnt   = drop_q;

endmodule
